// File: rtl/gui_overlay_sprite_if.sv
// rtl/gui_overlay_sprite_if.sv - scan position, ROM port and overlay outputs of the sprite renderer
interface gui_overlay_sprite_if #(
    parameter int AW = 15
);
    logic [9:0]    x;
    logic [9:0]    y;
    logic          frame_tick;
    logic          show;
    logic [AW-1:0] rom_addr;
    logic [11:0]   rom_data;
    logic [11:0]   rgb_out;
    logic          overlay_on;
    logic          anim_done;

    modport master (
        output x, y, frame_tick, show, rom_data,
        input  rom_addr, rgb_out, overlay_on, anim_done
    );

    modport slave (
        input  x, y, frame_tick, show, rom_data,
        output rom_addr, rgb_out, overlay_on, anim_done
    );
endinterface

// File: rtl/gui_overlay_sprite.sv
// rtl/gui_overlay_sprite.sv - scaled, colour-keyed sprite overlay with slide-in and blink animation
module gui_overlay_sprite #(
    parameter int          SPR_W        = 256,
    parameter int          SPR_H        = 128,
    parameter int          X_POS        = 192,
    parameter int          Y_POS        = 100,
    parameter int          SCALE_LOG2   = 0,
    parameter logic [11:0] KEY_RGB      = 12'hFF0,
    parameter int          ROM_LAT      = 1,
    parameter int          SLIDE_DIST   = 128,
    parameter int          SLIDE_STEP   = 4,
    parameter int          BLINK_FRAMES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gui_overlay_sprite_if.slave  bus
);
    localparam int AW    = $clog2(SPR_W * SPR_H);
    localparam int CW    = $clog2(SPR_W);
    localparam int RW    = AW - CW;
    localparam int WIN_W = SPR_W << SCALE_LOG2;
    localparam int WIN_H = SPR_H << SCALE_LOG2;
    localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, SLIDE, HOLD} state_t;

    state_t        state;
    logic [9:0]    slide_off;
    logic          blink_vis;
    logic [BW-1:0] blink_cnt;
    logic          anim_done;

    // slide_off only moves on frame_tick so the sprite geometry is stable for a whole frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            slide_off <= 10'(SLIDE_DIST);
            blink_vis <= 1'b1;
            blink_cnt <= '0;
            anim_done <= 1'b0;
        end else if (!bus.show) begin
            state     <= IDLE;
            slide_off <= 10'(SLIDE_DIST);
            blink_vis <= 1'b1;
            blink_cnt <= '0;
            anim_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    slide_off <= 10'(SLIDE_DIST);
                    if (SLIDE_DIST == 0) begin
                        state     <= HOLD;
                        anim_done <= 1'b1;
                    end else begin
                        state <= SLIDE;
                    end
                end
                SLIDE: begin
                    if (bus.frame_tick) begin
                        if (slide_off <= 10'(SLIDE_STEP)) begin
                            slide_off <= '0;
                            state     <= HOLD;
                            anim_done <= 1'b1;
                        end else begin
                            slide_off <= slide_off - 10'(SLIDE_STEP);
                        end
                    end
                end
                HOLD: begin
                    if ((BLINK_FRAMES != 0) && bus.frame_tick) begin
                        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                            blink_cnt <= '0;
                            blink_vis <= ~blink_vis;
                        end else begin
                            blink_cnt <= blink_cnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [10:0]   y0;
    logic [12:0]   dx;
    logic [12:0]   dy;
    logic          hit;
    logic          vis;
    logic [AW-1:0] addr_next;

    // y0 is an 11-bit two's-complement top edge; it goes negative while the sprite is above the screen
    always_comb begin
        y0        = 11'(Y_POS) - {1'b0, slide_off};
        dx        = {3'b000, bus.x} - 13'(X_POS);
        dy        = {3'b000, bus.y} - {{2{y0[10]}}, y0};
        hit       = !dx[12] && (dx < 13'(WIN_W)) && !dy[12] && (dy < 13'(WIN_H));
        vis       = (state != IDLE) && blink_vis;
        addr_next = '0;
        if (hit) begin
            addr_next = {RW'(dy >> SCALE_LOG2), CW'(dx >> SCALE_LOG2)};
        end
    end

    logic [AW-1:0]    rom_addr_r;
    logic [ROM_LAT:0] hit_pipe;
    logic [ROM_LAT:0] vis_pipe;
    logic             overlay_next;
    logic             overlay_on_r;
    logic [11:0]      rgb_r;

    always_comb begin
        overlay_next = hit_pipe[ROM_LAT] && vis_pipe[ROM_LAT] && (bus.rom_data != KEY_RGB);
    end

    // hit/vis travel beside the ROM read so they line up with the texel they qualify
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_r   <= '0;
            hit_pipe     <= '0;
            vis_pipe     <= '0;
            overlay_on_r <= 1'b0;
            rgb_r        <= 12'h000;
        end else begin
            rom_addr_r   <= addr_next;
            hit_pipe     <= {hit_pipe[ROM_LAT-1:0], hit};
            vis_pipe     <= {vis_pipe[ROM_LAT-1:0], vis};
            overlay_on_r <= overlay_next;
            rgb_r        <= overlay_next ? bus.rom_data : 12'h000;
        end
    end

    assign bus.rom_addr   = rom_addr_r;
    assign bus.overlay_on = overlay_on_r;
    assign bus.rgb_out    = rgb_r;
    assign bus.anim_done  = anim_done;
endmodule
